// File: rtl/toeplitz_pkg.sv
// Shared constants for the Toeplitz hash accumulator: default sizes,
// FSM state encodings and the row-counter width rule.
package toeplitz_pkg;

  localparam int HASH_W_DEF = 3072;
  localparam int ROWS_DEF   = 4096;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must be able to hold every row index 0..ROWS-1 with headroom.
  function automatic int cnt_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(ROWS_DEF);

endpackage

// File: rtl/gf2_row_mac.sv
// GF(2) row multiply-accumulate: XOR the row into the base when the bit is set.
module gf2_row_mac #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_row,
  input  logic         i_bit,
  output logic [W-1:0] o_acc
);

  assign o_acc = i_base ^ (i_row & {W{i_bit}});

endmodule

// File: rtl/toeplitz_accum.sv
// Accumulates ROWS Toeplitz rows, each gated by one raw bit, into a HASH_W-bit
// hash and hands it downstream with a valid/ready handshake.
module toeplitz_accum
  import toeplitz_pkg::*;
#(
  parameter int HASH_W = HASH_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int CNT_W  = cnt_w(ROWS)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              sum_en,
  input  logic [HASH_W-1:0] shift_result,
  input  logic              raw_bit,
  output logic              raw_rd_en,
  output logic [HASH_W-1:0] hash_out,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic              busy,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS - 1);

  logic [1:0]        r_state;
  logic [HASH_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_row_cnt;
  logic [HASH_W-1:0] r_hash;
  logic              r_valid;
  logic              r_overrun;

  logic              w_consume;
  logic [HASH_W-1:0] w_base;
  logic [HASH_W-1:0] w_acc_next;
  logic [CNT_W-1:0]  w_row_idx;
  logic              w_last;

  // A row taken in DONE starts a fresh block, so it sees a zero base and index 0.
  assign w_consume = sum_en && ((r_state != ST_DONE) || hash_ready);
  assign w_base    = (r_state == ST_DONE) ? '0 : r_acc;
  assign w_row_idx = (r_state == ST_ACC) ? r_row_cnt : '0;
  assign w_last    = (w_row_idx == LAST_IDX);

  gf2_row_mac #(
    .W (HASH_W)
  ) u_mac (
    .i_base (w_base),
    .i_row  (shift_result),
    .i_bit  (raw_bit),
    .o_acc  (w_acc_next)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_row_cnt <= '0;
      r_hash    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_consume) begin
      if (w_last) begin
        r_hash    <= w_acc_next;
        r_valid   <= 1'b1;
        r_acc     <= '0;
        r_row_cnt <= '0;
        r_state   <= ST_DONE;
      end else begin
        r_acc     <= w_acc_next;
        r_row_cnt <= w_row_idx + CNT_W'(1);
        r_valid   <= 1'b0;
        r_state   <= ST_ACC;
      end
    end else begin
      case (r_state)
        ST_IDLE, ST_ACC: ;
        ST_DONE: begin
          if (hash_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end else if (sum_en) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign raw_rd_en  = w_consume && !rst;
  assign hash_out   = r_hash;
  assign hash_valid = r_valid;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_toeplitz_accum.sv
// Scoreboarded bench for toeplitz_accum with HASH_W=8 (ROWS=4 and ROWS=1 instances).
module tb_toeplitz_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sum_en = 1'b0;
  logic       sum_en1 = 1'b0;
  logic [7:0] shift_result = 8'h00;
  logic       raw_bit = 1'b0;
  logic       hash_ready = 1'b0;

  logic       raw_rd_en, hash_valid, busy, overrun;
  logic [7:0] hash_out;
  logic       raw_rd_en1, hash_valid1, busy1, overrun1;
  logic [7:0] hash_out1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb_q[$];
  logic [7:0] sb_acc = 8'h00;
  int         sb_n = 0;

  always #5 clk = ~clk;

  toeplitz_accum #(.HASH_W(8), .ROWS(4)) dut (
    .clk_in(clk), .rst(rst), .sum_en(sum_en), .shift_result(shift_result),
    .raw_bit(raw_bit), .raw_rd_en(raw_rd_en), .hash_out(hash_out),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .busy(busy), .overrun(overrun)
  );

  toeplitz_accum #(.HASH_W(8), .ROWS(1)) dut1 (
    .clk_in(clk), .rst(rst), .sum_en(sum_en1), .shift_result(shift_result),
    .raw_bit(raw_bit), .raw_rd_en(raw_rd_en1), .hash_out(hash_out1),
    .hash_valid(hash_valid1), .hash_ready(hash_ready), .busy(busy1), .overrun(overrun1)
  );

  // Drive one cycle of inputs on the falling edge; return 1 time unit later.
  task automatic cyc(input logic s, input logic [7:0] r, input logic b,
                     input logic y, input logic s1);
    @(negedge clk);
    sum_en = s; shift_result = r; raw_bit = b; hash_ready = y; sum_en1 = s1;
    #1;
  endtask

  // Reference GF(2) accumulation for the ROWS=4 instance.
  task automatic sb_row(input logic [7:0] r, input logic b);
    sb_acc = sb_acc ^ (b ? r : 8'h00);
    sb_n++;
    if (sb_n == 4) begin
      sb_q.push_back(sb_acc);
      sb_acc = 8'h00;
      sb_n = 0;
    end
  endtask

  task automatic run_block(input int gap, input logic [3:0] bm);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h01 << i), bm[i], 1'b0, 1'b0);
      sb_row(8'(8'h01 << i), bm[i]);
      if (i < 3) repeat (gap) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sum_en = 1'b1; shift_result = 8'hAA; raw_bit = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (raw_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_rd_en: got %b want 0", raw_rd_en);
    end
    vectors++;
    if ({hash_valid, hash_out, busy, overrun, hash_valid1} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b hash=%h busy=%b ovr=%b valid1=%b want all 0",
               hash_valid, hash_out, busy, overrun, hash_valid1);
    end
    rst = 1'b0; sum_en = 1'b0; raw_bit = 1'b0; shift_result = 8'h00;
  endtask

  task automatic test_contig;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h01 << i), (i != 1), 1'b0, 1'b0);
      sb_row(8'(8'h01 << i), (i != 1));
      vectors++;
      if (raw_rd_en !== 1'b1 || hash_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL contig_row%0d: rd_en=%b valid=%b want 1/0", i, raw_rd_en, hash_valid);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0]) begin
      miscompares++;
      $display("FAIL contig_hash: valid=%b hash=%h want 1/%h", hash_valid, hash_out,
               (sb_q.size() != 0) ? sb_q[0] : 8'hxx);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || hash_out !== 8'h0D || raw_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL contig_hold: valid=%b hash=%h rd=%b want 1/0d/0", hash_valid, hash_out, raw_rd_en);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL contig_release: valid=%b busy=%b want 0/0", hash_valid, busy);
    end
  endtask

  task automatic test_gaps;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h01 << i), (i != 1), 1'b0, 1'b0);
      sb_row(8'(8'h01 << i), (i != 1));
      vectors++;
      if (raw_rd_en !== 1'b1) begin
        miscompares++; $display("FAIL gaps_rd_row%0d: got %b want 1", i, raw_rd_en);
      end
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
          vectors++;
          if (raw_rd_en !== 1'b0 || hash_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_idle%0d_%0d: rd=%b valid=%b busy=%b want 0/0/1",
                     i, g, raw_rd_en, hash_valid, busy);
          end
        end
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0] || hash_out !== 8'h0D) begin
      miscompares++;
      $display("FAIL gaps_hash: valid=%b hash=%h want 1/0d", hash_valid, hash_out);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_block(0, 4'b1101);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0]) begin
      miscompares++; $display("FAIL b2b_blockA: valid=%b hash=%h want 1/0d", hash_valid, hash_out);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0);
    sb_row(8'hF0, 1'b1);
    vectors++;
    if (raw_rd_en !== 1'b1) begin
      miscompares++; $display("FAIL b2b_rd_in_done: got %b want 1", raw_rd_en);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      sb_row(8'h00, 1'b1);
      vectors++;
      if (hash_valid !== 1'b0 || raw_rd_en !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_row%0d: valid=%b rd=%b want 0/1", i + 1, hash_valid, raw_rd_en);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0] ||
        hash_out !== 8'hF0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_blockB: valid=%b hash=%h ovr=%b want 1/f0/0", hash_valid, hash_out, overrun);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overrun;
    run_block(0, 4'b1101);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (raw_rd_en !== 1'b0) begin
        miscompares++; $display("FAIL overrun_rd%0d: got %b want 0", i, raw_rd_en);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (overrun !== 1'b1 || hash_valid !== 1'b1 || hash_out !== 8'h0D) begin
      miscompares++;
      $display("FAIL overrun_flag: ovr=%b valid=%b hash=%h want 1/1/0d", overrun, hash_valid, hash_out);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); sb_row(8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0); sb_row(8'h22, 1'b1);
    cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b0); sb_row(8'h44, 1'b0);
    cyc(1'b1, 8'h80, 1'b1, 1'b0, 1'b0); sb_row(8'h80, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0] ||
        hash_out !== 8'hB3 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_fresh: valid=%b hash=%h ovr=%b want 1/b3/1", hash_valid, hash_out, overrun);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; sum_en = 1'b1; shift_result = 8'h33; raw_bit = 1'b1;
    #1;
    vectors++;
    if (raw_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_rd: got %b want 0", raw_rd_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; sum_en = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({hash_valid, hash_out, busy, overrun} !== 11'h000) begin
      miscompares++;
      $display("FAIL rstmid_outputs: valid=%b hash=%h busy=%b ovr=%b want all 0",
               hash_valid, hash_out, busy, overrun);
    end
    run_block(0, 4'b1111);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0] || hash_out !== 8'h0F) begin
      miscompares++;
      $display("FAIL rstmid_hash: valid=%b hash=%h want 1/0f", hash_valid, hash_out);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_bits;
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      cyc(1'b1, r, 1'b0, 1'b0, 1'b0);
      sb_row(r, 1'b0);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid !== 1'b1 || sb_q.size() == 0 || hash_out !== sb_q[0] || hash_out !== 8'h00) begin
      miscompares++;
      $display("FAIL zero_bits: valid=%b hash=%h want 1/00", hash_valid, hash_out);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_rows1;
    cyc(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (raw_rd_en1 !== 1'b1 || hash_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rows1_consume: rd=%b valid=%b want 1/0", raw_rd_en1, hash_valid1);
    end
    cyc(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (hash_valid1 !== 1'b1 || hash_out1 !== 8'hA5 || raw_rd_en1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rows1_hash: valid=%b hash=%h rd=%b want 1/a5/1", hash_valid1, hash_out1, raw_rd_en1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (hash_valid1 !== 1'b1 || hash_out1 !== 8'h3C || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rows1_b2b: valid=%b hash=%h busy=%b want 1/3c/1", hash_valid1, hash_out1, busy1);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (hash_valid1 !== 1'b0 || busy1 !== 1'b0 || overrun1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rows1_release: valid=%b busy=%b ovr=%b want 0/0/0", hash_valid1, busy1, overrun1);
    end
  endtask

  initial begin
    test_reset();
    test_contig();
    test_gaps();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_zero_bits();
    test_rows1();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d hashes left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/toeplitz_accum.md
Name: toeplitz_accum

Overview:
- Downstream of the seed shifter. Consumes one shifted Toeplitz row (HASH_W bits) per cycle while sum_en is high.
- Pairs each row with one raw input bit taken from a first-word-fall-through (FWFT) raw-data FIFO.
- GF(2) multiply-accumulate: when the raw bit is 1, the row is XORed into the accumulator.
- After ROWS rows, presents the HASH_W-bit hash with a valid/ready handshake to the output writer.

Parameters:
- HASH_W, 3072: row width = hash output width.
- ROWS, 4096: rows (raw bits) per hash block; must be >= 1.
- CNT_W, 13: row counter width; must satisfy 2^CNT_W > ROWS.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- sum_en  in  1  row valid from the seed shifter; one row per cycle while high.
- shift_result  in  HASH_W  current Toeplitz row.
- raw_bit  in  1  FWFT head of the raw-data FIFO, valid whenever sum_en is high.
- raw_rd_en  out  1  combinational pop to the raw FIFO; high exactly in cycles where a row is consumed.
- hash_out  out  HASH_W  finished hash; stable while hash_valid is high.
- hash_valid  out  1  hash available.
- hash_ready  in  1  downstream accepts the hash.
- busy  out  1  high in ACC or DONE.
- overrun  out  1  sticky; set when sum_en arrives in DONE without hash_ready.

Behaviour:
- Reset (synchronous, rst high at the edge), from any state including mid-block:
  - state <= IDLE; acc <= 0; row_cnt <= 0; hash_out <= 0; hash_valid <= 0; overrun <= 0.
  - raw_rd_en is 0 while rst is high.
- Consume condition: consume = sum_en && (state != DONE || hash_ready). raw_rd_en = consume && !rst.
- Row contribution: term = raw_bit ? shift_result : 0.
- Accumulate base: base = (state == DONE) ? 0 : acc. acc_next = base ^ term. The operation is pure XOR, with no carries.
- States: IDLE=2'd0, ACC=2'd1, DONE=2'd2.
- IDLE:
  - acc == 0 and row_cnt == 0.
  - If consume: acc <= acc_next, row_cnt <= 1, go to ACC. Exception: if ROWS == 1, go straight to the completion action.
- ACC:
  - Gaps are allowed. With sum_en = 0, state, acc and row_cnt hold.
  - If consume and row_cnt == ROWS-1 (last row): completion action.
  - Otherwise, if consume: acc <= acc_next, row_cnt <= row_cnt+1.
- Completion action:
  - hash_out <= acc_next; hash_valid <= 1; acc <= 0; row_cnt <= 0; go to DONE.
  - Latency: hash_valid rises the cycle after the last row is consumed.
- DONE:
  - hash_valid is held and hash_out is stable until hash_ready.
  - hash_ready with no sum_en: hash_valid <= 0, go to IDLE.
  - hash_ready and sum_en in the same cycle: the handshake completes and the row is consumed as row 0 of the next block (base = 0). hash_valid <= 0 unless ROWS == 1, in which case hash_valid stays 1 with a new hash_out. Go to ACC (or stay in DONE when ROWS == 1).
  - sum_en with no hash_ready: the row is not consumed, raw_rd_en = 0, overrun <= 1 (cleared only by rst), state holds.
- busy = (state != IDLE).
- row_cnt never exceeds ROWS-1; there is no wrap-around beyond the completion action.

Decomposition:
- Package toeplitz_pkg holds:
  - default HASH_W and ROWS;
  - state encodings IDLE/ACC/DONE;
  - CNT_W, derived as $clog2(ROWS+1).
- One natural sub-module: gf2_row_mac, a combinational block.
  - Inputs: base, row, bit.
  - Output: base ^ (bit ? row : 0).
  - Reusable by a later multi-lane version.
- FSM, counter and handshake stay in toeplitz_accum.

Test Plan (HASH_W=8, ROWS=4 unless noted):
- Rows 0x01, 0x02, 0x04, 0x08 with raw bits 1, 0, 1, 1, sum_en contiguous -> raw_rd_en high 4 cycles; hash_valid rises 1 cycle after row 4; hash_out = 0x0D, held until hash_ready.
- Same rows with 3-cycle sum_en gaps between rows -> same 0x0D; raw_rd_en high only on the 4 sum_en cycles.
- Block A (result 0x0D) held in DONE; hash_ready and sum_en asserted together with row 0xF0, bit 1, then rows 0x00, 0x00, 0x00 -> A handshakes; block B hash_out = 0xF0; overrun stays 0.
- Hold DONE with hash_ready = 0 and pulse sum_en 2 cycles -> raw_rd_en = 0, overrun = 1, hash_out unchanged 0x0D; after hash_ready the next block is computed from fresh rows.
- Assert rst after 2 rows of a block -> the next cycle shows all outputs 0 and state IDLE; a full new 4-row block yields a correct hash, with no residue from the aborted rows.
- All raw bits 0 with random rows -> hash_out = 0x00; ROWS=1 variant with row 0xA5, bit 1 -> hash_out = 0xA5 one cycle later.
